// File: rtl/byte_ser_pkg.sv
// Shared types and constants for the byte serializer.
package byte_ser_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } byte_ser_state_t;

endpackage

// File: rtl/byte_ser_if.sv
// Byte handshake, pacing tick and serial output bundle for byte_ser.
interface byte_ser_if;

  logic [byte_ser_pkg::DATA_W-1:0] data_in;
  logic                            in_valid;
  logic                            in_ready;
  logic                            bit_en;
  logic                            ser_out;
  logic                            ser_frame;
  logic                            ser_last;
  logic                            done;

  modport master (
    output data_in, in_valid, bit_en,
    input  in_ready, ser_out, ser_frame, ser_last, done
  );

  modport slave (
    input  data_in, in_valid, bit_en,
    output in_ready, ser_out, ser_frame, ser_last, done
  );

endinterface

// File: rtl/byte_ser.sv
// Parallel-to-serial stage: one byte per handshake, shifted out MSB-first per bit_en tick.
// Optional trailing parity bit is compiled in with BYTE_SER_PARITY_EN.
//
//   state | meaning
//   IDLE  | ready for a byte, serial outputs quiet
//   SHIFT | presenting shreg MSB, advancing on bit_en
//   PAR   | presenting latched parity bit (parity build only)
module byte_ser #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic      clk,
  input  logic      rst,
  byte_ser_if.slave bus
);
  import byte_ser_pkg::*;

  if (DATA_W != byte_ser_pkg::DATA_W) begin : g_bad_data_w
    $error("byte_ser supports only an 8-bit byte");
  end
  if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_bad_parity
    $error("ODD_PARITY must be 0 or 1");
  end

  byte_ser_state_t   state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_frame_q, ser_frame_d;
  logic              ser_last_q, ser_last_d;
  logic              done_q, done_d;
`ifdef BYTE_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef BYTE_SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
`ifdef BYTE_SER_PARITY_EN
          par_d   = (^bus.data_in) ^ (ODD_PARITY != 0);
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_en) begin
          if (cnt_q != CNT_LAST) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
`ifdef BYTE_SER_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef BYTE_SER_PARITY_EN
      PAR: begin
        if (bus.bit_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Serial outputs are decoded from the next state so they register in step with it.
    ser_frame_d = (state_d != IDLE);
    ser_out_d   = 1'b0;
    ser_last_d  = 1'b0;
    if (state_d == SHIFT) begin
      ser_out_d = shreg_d[DATA_W-1];
`ifndef BYTE_SER_PARITY_EN
      ser_last_d = (cnt_d == CNT_LAST);
`endif
    end
`ifdef BYTE_SER_PARITY_EN
    if (state_d == PAR) begin
      ser_out_d  = par_d;
      ser_last_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      ser_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef BYTE_SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      ser_last_q  <= ser_last_d;
      done_q      <= done_d;
`ifdef BYTE_SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_frame = ser_frame_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_byte_ser.sv
// Self-checking bench for byte_ser: directed frames plus randomized bytes and bit_en pacing.
module tb_byte_ser;

  parameter int ODD_PARITY = 0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  byte_ser_if bif ();

  byte_ser #(.DATA_W(8), .ODD_PARITY(ODD_PARITY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_quiet(input string pfx, input logic exp_done);
    check_eq({pfx, "_frame"}, 32'(bif.ser_frame), 32'd0);
    check_eq({pfx, "_out"},   32'(bif.ser_out),   32'd0);
    check_eq({pfx, "_last"},  32'(bif.ser_last),  32'd0);
    check_eq({pfx, "_done"},  32'(bif.done),      32'(exp_done));
    check_eq({pfx, "_rdy"},   32'(bif.in_ready),  32'd1);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check_quiet("idle", 1'b0);
    end
  endtask

  // Called at a negedge with the DUT idle. period 0 = random bit_en, else a tick every
  // period-th cycle. hold keeps in_valid high through the frame for a chained next byte.
  task automatic run_frame(input logic [7:0] b, input int period, input bit hold);
    bit exp_q[$];
    int k;
    int ticks;
    int nb;
    bit en;
    exp_q = {};
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
`ifdef BYTE_SER_PARITY_EN
    exp_q.push_back(bit'(($countones(b) + ODD_PARITY) % 2));
`endif
    nb = exp_q.size();
    check_eq("start_rdy",   32'(bif.in_ready),  32'd1);
    check_eq("start_frame", 32'(bif.ser_frame), 32'd0);
    bif.in_valid = 1'b1;
    bif.data_in  = b;
    bif.bit_en   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bif.in_valid = hold;
    bif.data_in  = 8'($urandom);
    ticks = 0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (ticks == nb) begin
        check_quiet("end", 1'b1);
        break;
      end
      if (k > 400) begin
        check_eq("frame_timeout", 32'(ticks), 32'(nb));
        break;
      end
      check_eq("frame", 32'(bif.ser_frame), 32'd1);
      check_eq("bit",   32'(bif.ser_out),   32'(exp_q[ticks]));
      check_eq("last",  32'(bif.ser_last),  32'(ticks == nb - 1));
      check_eq("done",  32'(bif.done),      32'd0);
      check_eq("rdy",   32'(bif.in_ready),  32'd0);
      en = (period == 0) ? bit'($urandom_range(0, 1)) : ((k % period) == 0);
      bif.bit_en = en;
      if (en) ticks++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         p;
    bit         h;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.data_in  = 8'h00;
    bif.bit_en   = 1'b0;

    @(negedge clk);
    check_quiet("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(2);

    // Directed frames: constant bit_en, slow pacing, LSB-only byte.
    run_frame(8'hA5, 1, 1'b0);
    idle_check(2);
    run_frame(8'h80, 3, 1'b0);
    idle_check(1);
    run_frame(8'h01, 1, 1'b0);
    idle_check(1);

    // in_valid held high: second byte taken on the single IDLE cycle.
    run_frame(8'h3C, 1, 1'b1);
    run_frame(8'hC3, 1, 1'b0);
    idle_check(2);

    // Reset in the middle of bit 4 of 0xFF.
    check_eq("rst_mid_rdy", 32'(bif.in_ready), 32'd1);
    bif.in_valid = 1'b1;
    bif.data_in  = 8'hFF;
    bif.bit_en   = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_mid_pre_frame", 32'(bif.ser_frame), 32'd1);
    check_eq("rst_mid_pre_out",   32'(bif.ser_out),   32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("rst_async", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(4);

    // Handshake attempts during reset are dropped.
    rst = 1'b1;
    bif.in_valid = 1'b1;
    bif.data_in  = 8'h55;
    repeat (2) begin
      @(negedge clk);
      check_quiet("rst_hs", 1'b0);
    end
    bif.in_valid = 1'b0;
    rst = 1'b0;
    idle_check(3);

    // in_valid still high at reset release starts a frame.
    rst = 1'b1;
    bif.in_valid = 1'b1;
    bif.data_in  = 8'h5A;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(8'h5A, 1, 1'b0);
    idle_check(1);

    // Randomized bytes, pacing and chaining.
    for (int f = 0; f < 24; f++) begin
      b = 8'($urandom);
      p = $urandom_range(0, 3);
      h = (f < 23) ? bit'($urandom_range(0, 1)) : 1'b0;
      run_frame(b, p, h);
      if (!h) idle_check($urandom_range(0, 2));
    end
    bif.in_valid = 1'b0;
    idle_check(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
